// File: rtl/branch_predictor_unit_pkg.sv
// branch_predictor_unit_pkg: shared defaults, BTB entry layout and PT counter helpers
package branch_predictor_unit_pkg;
  localparam int DEF_DBITS          = 32;
  localparam int DEF_BHR_BITS       = 8;
  localparam int DEF_PT_INDEX_BITS  = 8;
  localparam int DEF_BTB_INDEX_BITS = 6;
  localparam int DEF_CTR_BITS       = 2;
  localparam int DEF_GSHARE         = 1;
  localparam int DEF_CNT_BITS       = 32;
  localparam int DEF_TAG_BITS       = DEF_DBITS - DEF_BTB_INDEX_BITS - 2;
  // Weakly not-taken reset value of a default-width counter
  localparam logic [DEF_CTR_BITS-1:0] WEAK_NT = DEF_CTR_BITS'((1 << (DEF_CTR_BITS - 1)) - 1);

  typedef struct packed {
    logic                    valid;
    logic [DEF_TAG_BITS-1:0] tag;
    logic [DEF_DBITS-1:0]    target;
  } btb_entry_t;

  function automatic logic [31:0] ctr_inc(input logic [31:0] c, input logic [31:0] max);
    return c == max ? c : c + 32'd1;
  endfunction

  function automatic logic [31:0] ctr_dec(input logic [31:0] c);
    return c == 32'd0 ? c : c - 32'd1;
  endfunction

  function automatic logic [31:0] ctr_weak_nt(input int bits);
    return (32'd1 << (bits - 1)) - 32'd1;
  endfunction
endpackage

// File: rtl/branch_predictor_unit_sat_counter_table.sv
// sat_counter_table: pattern table of saturating counters, one read port and one update port
module sat_counter_table
  import branch_predictor_unit_pkg::*;
#(
  parameter int IDX_BITS = DEF_PT_INDEX_BITS,
  parameter int CTR_BITS = DEF_CTR_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_BITS-1:0] rd_idx_i,
  output logic                rd_msb_o,
  input  logic                we_i,
  input  logic [IDX_BITS-1:0] wr_idx_i,
  input  logic                taken_i
);
  localparam int MAX = (1 << CTR_BITS) - 1;
  localparam logic [CTR_BITS-1:0] INIT = CTR_BITS'(ctr_weak_nt(CTR_BITS));
  logic [CTR_BITS-1:0] ctr_q [1 << IDX_BITS];
  logic [CTR_BITS-1:0] ctr_d;
  assign rd_msb_o = ctr_q[rd_idx_i][CTR_BITS-1];
  assign ctr_d = CTR_BITS'(taken_i ? ctr_inc(32'(ctr_q[wr_idx_i]), MAX) : ctr_dec(32'(ctr_q[wr_idx_i])));
  // Counters reset to weakly not-taken; the addressed counter steps toward the resolved direction
  always_ff @(posedge clk or posedge reset)
    if (reset) for (int i = 0; i < (1 << IDX_BITS); i++) ctr_q[i] <= INIT;
    else if (we_i) ctr_q[wr_idx_i] <= ctr_d;
endmodule

// File: rtl/branch_predictor_unit.sv
// branch_predictor_unit: BHR + PT + BTB lookup for FE, resolved-branch update from AGEX, statistics
module branch_predictor_unit
  import branch_predictor_unit_pkg::*;
#(
  parameter int DBITS          = DEF_DBITS,
  parameter int BHR_BITS       = DEF_BHR_BITS,
  parameter int PT_INDEX_BITS  = DEF_PT_INDEX_BITS,
  parameter int BTB_INDEX_BITS = DEF_BTB_INDEX_BITS,
  parameter int CTR_BITS       = DEF_CTR_BITS,
  parameter int GSHARE         = DEF_GSHARE,
  parameter int CNT_BITS       = DEF_CNT_BITS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DBITS-1:0]         lk_pc,
  output logic                     pred_taken,
  output logic [DBITS-1:0]         pred_target,
  output logic                     pred_btb_hit,
  output logic [PT_INDEX_BITS-1:0] pred_pt_idx,
  input  logic                     up_valid,
  input  logic                     up_cond,
  input  logic [DBITS-1:0]         up_pc,
  input  logic                     up_taken,
  input  logic [DBITS-1:0]         up_target,
  input  logic [PT_INDEX_BITS-1:0] up_pt_idx,
  input  logic                     up_mispredict,
  output logic [CNT_BITS-1:0]      stat_branches,
  output logic [CNT_BITS-1:0]      stat_mispredicts
);
  localparam int TAG_BITS = DBITS - BTB_INDEX_BITS - 2;
  // Same layout as btb_entry_t, resized to this instance's address and index widths
  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [DBITS-1:0]    target;
  } btb_t;
  btb_t                      btb_q [1 << BTB_INDEX_BITS];
  logic [BHR_BITS-1:0]       bhr_q, bhr_d;
  logic [CNT_BITS-1:0]       br_q, br_d, mp_q, mp_d;
  logic [BTB_INDEX_BITS-1:0] lk_slot, up_slot;
  logic [PT_INDEX_BITS-1:0]  lk_idx;
  logic                      pt_msb;
  logic                      unused_pc_lsb;
  assign unused_pc_lsb = &{1'b0, up_pc[1:0]};
  assign lk_slot = lk_pc[BTB_INDEX_BITS+1:2];
  assign up_slot = up_pc[BTB_INDEX_BITS+1:2];
  assign lk_idx = lk_pc[PT_INDEX_BITS+1:2] ^ (GSHARE != 0 ? PT_INDEX_BITS'(bhr_q) : '0);
  assign pred_pt_idx = lk_idx;
  assign pred_btb_hit = btb_q[lk_slot].valid && btb_q[lk_slot].tag == lk_pc[DBITS-1:BTB_INDEX_BITS+2];
  assign pred_taken = pred_btb_hit && pt_msb;
  assign pred_target = pred_taken ? btb_q[lk_slot].target : lk_pc + DBITS'(4);
  assign bhr_d = up_valid && up_cond ? BHR_BITS'({bhr_q, up_taken}) : bhr_q;
  assign br_d = up_valid && br_q != '1 ? br_q + 1'b1 : br_q;
  assign mp_d = up_valid && up_mispredict && mp_q != '1 ? mp_q + 1'b1 : mp_q;
  assign stat_branches = br_q;
  assign stat_mispredicts = mp_q;

  sat_counter_table #(.IDX_BITS(PT_INDEX_BITS), .CTR_BITS(CTR_BITS)) u_pt (
    .clk      (clk),
    .reset    (reset),
    .rd_idx_i (lk_idx),
    .rd_msb_o (pt_msb),
    .we_i     (up_valid && up_cond),
    .wr_idx_i (up_pt_idx),
    .taken_i  (up_taken)
  );

  // History, statistics and BTB fill from resolved branches; taken ones overwrite their BTB slot
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bhr_q <= '0;
      br_q  <= '0;
      mp_q  <= '0;
      for (int i = 0; i < (1 << BTB_INDEX_BITS); i++) btb_q[i] <= '0;
    end else begin
      bhr_q <= bhr_d;
      br_q  <= br_d;
      mp_q  <= mp_d;
      if (up_valid && up_taken) btb_q[up_slot] <= '{valid: 1'b1, tag: up_pc[DBITS-1:BTB_INDEX_BITS+2], target: up_target};
    end
endmodule
